// File: rtl/pacman_pkg.sv
// Shared maze geometry, initial dot bitmap and tracker state type for the
// Pac-Man game-state pipeline.
package pacman_pkg;

  localparam int unsigned GRID_ORIGIN = 56;
  localparam int unsigned TILE        = 8;
  localparam int unsigned GRID_N      = 42;

  // Indexed [col][row]; bit set = dot present.
  typedef logic [GRID_N-1:0][GRID_N-1:0] dot_map_t;

  typedef enum logic [1:0] {RUN, REVERSAL, CLEAR} tracker_state_t;

  // Walls are isolated pillars on every 7th tile in both axes.
  function automatic dot_map_t build_dot_init();
    dot_map_t m;
    m = '1;
    for (int unsigned c = 0; c < GRID_N; c++)
      for (int unsigned r = 0; r < GRID_N; r++)
        if ((c % 7) == 3 && (r % 7) == 3) m[c][r] = 1'b0;
    return m;
  endfunction

  function automatic logic [10:0] count_dots(dot_map_t m);
    logic [10:0] n;
    n = '0;
    for (int unsigned c = 0; c < GRID_N; c++)
      for (int unsigned r = 0; r < GRID_N; r++)
        n = n + 11'(m[c][r]);
    return n;
  endfunction

  localparam dot_map_t    DOT_INIT       = build_dot_init();
  localparam logic [10:0] DOT_INIT_COUNT = count_dots(DOT_INIT);

endpackage

// File: rtl/pellet_tracker_if.sv
// Per-frame game inputs and the bitmap/flags handed on to color_mapper.
interface pellet_tracker_if;
  import pacman_pkg::*;

  logic        frame_tick;
  logic        freeze;
  logic [9:0]  pacmanX;
  logic [9:0]  pacmanY;
  logic [9:0]  fruit_location [6];
  dot_map_t    dots;
  logic        first_on;
  logic        second_on;
  logic        third_on;
  logic        reversal;
  logic [15:0] score;
  logic [10:0] dots_left;
  logic        level_clear;

  modport master (
    output frame_tick, freeze, pacmanX, pacmanY, fruit_location,
    input  dots, first_on, second_on, third_on, reversal, score, dots_left, level_clear
  );

  modport slave (
    input  frame_tick, freeze, pacmanX, pacmanY, fruit_location,
    output dots, first_on, second_on, third_on, reversal, score, dots_left, level_clear
  );
endinterface

// File: rtl/pellet_tracker_fruit_hit.sv
// Combinational overlap test: Pac-Man within 8 pixels of a fruit on both axes.
module fruit_hit (
  input  logic [9:0] pac_x,
  input  logic [9:0] pac_y,
  input  logic [9:0] fruit_x,
  input  logic [9:0] fruit_y,
  output logic       hit
);
  logic signed [10:0] dx;
  logic signed [10:0] dy;

  always_comb begin
    dx  = $signed({1'b0, pac_x}) - $signed({1'b0, fruit_x});
    dy  = $signed({1'b0, pac_y}) - $signed({1'b0, fruit_y});
    hit = (dx > -11'sd8) && (dx < 11'sd8) && (dy > -11'sd8) && (dy < 11'sd8);
  end
endmodule

// File: rtl/pellet_tracker.sv
// Per-frame dot/fruit consumption, score keeping and frightened-mode timer
// feeding color_mapper.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int unsigned REV_FRAMES = 300,
  parameter int unsigned DOT_PTS    = 10,
  parameter int unsigned FRUIT_PTS  = 50,
  parameter dot_map_t    DOT_MASK   = DOT_INIT
) (
  input logic              Clk,
  input logic              Reset_n,
  pellet_tracker_if.slave  bus
);
  localparam logic [10:0] DOT_COUNT = count_dots(DOT_MASK);
  localparam logic [9:0]  LO        = 10'(GRID_ORIGIN);
  localparam logic [9:0]  HI        = 10'(GRID_ORIGIN + TILE * (GRID_N - 1));

  tracker_state_t state;
  dot_map_t       dots_q;
  logic [15:0]    score_q;
  logic [10:0]    left_q;
  logic [2:0]     fruit_en;
  logic [15:0]    rev_cnt;

  logic [9:0]  off_x, off_y;
  logic [5:0]  col, row;
  logic        tile_ok, dot_hit, evaluate;
  logic [2:0]  fruit_hit_v, fruit_eat;
  logic [1:0]  n_fruit;
  logic [16:0] sum;
  logic [15:0] score_nx;
  logic [10:0] left_nx;

  fruit_hit u_fruit0 (.pac_x(bus.pacmanX), .pac_y(bus.pacmanY),
    .fruit_x(bus.fruit_location[0]), .fruit_y(bus.fruit_location[1]), .hit(fruit_hit_v[0]));
  fruit_hit u_fruit1 (.pac_x(bus.pacmanX), .pac_y(bus.pacmanY),
    .fruit_x(bus.fruit_location[2]), .fruit_y(bus.fruit_location[3]), .hit(fruit_hit_v[1]));
  fruit_hit u_fruit2 (.pac_x(bus.pacmanX), .pac_y(bus.pacmanY),
    .fruit_x(bus.fruit_location[4]), .fruit_y(bus.fruit_location[5]), .hit(fruit_hit_v[2]));

  always_comb begin
    off_x   = '0;
    off_y   = '0;
    col     = '0;
    row     = '0;
    tile_ok = 1'b0;
    // Subtract only inside the window so the offsets never wrap.
    if (bus.pacmanX >= LO && bus.pacmanX <= HI && bus.pacmanY >= LO && bus.pacmanY <= HI) begin
      off_x   = bus.pacmanX - LO;
      off_y   = bus.pacmanY - LO;
      tile_ok = (off_x[2:0] == 3'd0) && (off_y[2:0] == 3'd0);
      col     = 6'(off_x >> 3);
      row     = 6'(off_y >> 3);
    end
    dot_hit   = tile_ok && dots_q[col][row];
    fruit_eat = fruit_hit_v & fruit_en;
    n_fruit   = {1'b0, fruit_eat[0]} + {1'b0, fruit_eat[1]} + {1'b0, fruit_eat[2]};
    sum       = {1'b0, score_q} + (dot_hit ? 17'(DOT_PTS) : 17'd0)
              + 17'(n_fruit) * 17'(FRUIT_PTS);
    score_nx  = sum[16] ? '1 : sum[15:0];
    left_nx   = (dot_hit && left_q != '0) ? left_q - 11'd1 : left_q;
    evaluate  = bus.frame_tick && !bus.freeze && state != CLEAR;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= RUN;
      dots_q   <= DOT_MASK;
      score_q  <= '0;
      left_q   <= DOT_COUNT;
      fruit_en <= '1;
      rev_cnt  <= '0;
    end else if (evaluate) begin
      score_q  <= score_nx;
      left_q   <= left_nx;
      fruit_en <= fruit_en & ~fruit_eat;
      if (dot_hit) dots_q[col][row] <= 1'b0;
      if (left_nx == '0) begin
        state   <= CLEAR;
        rev_cnt <= '0;
      end else if (|fruit_eat) begin
        state   <= REVERSAL;
        rev_cnt <= 16'(REV_FRAMES);
      end else if (state == REVERSAL) begin
        if (rev_cnt == 16'd1) begin
          state   <= RUN;
          rev_cnt <= '0;
        end else begin
          rev_cnt <= rev_cnt - 16'd1;
        end
      end
    end
  end

  assign bus.dots        = dots_q;
  assign bus.score       = score_q;
  assign bus.dots_left   = left_q;
  assign bus.first_on    = fruit_en[0];
  assign bus.second_on   = fruit_en[1];
  assign bus.third_on    = fruit_en[2];
  assign bus.reversal    = (state == REVERSAL);
  assign bus.level_clear = (state == CLEAR);
endmodule

// File: tb/tb_pellet_tracker.sv
// Directed and randomized frames against a per-tile / per-fruit reference model.
module tb_pellet_tracker;
  import pacman_pkg::*;

  localparam int REV = 300;
  localparam int DP  = 10;
  localparam int FP  = 50;
  localparam dot_map_t ONE_DOT = dot_map_t'(1);

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  pellet_tracker_if ia ();
  pellet_tracker_if ib ();

  pellet_tracker #(.REV_FRAMES(REV), .DOT_PTS(DP), .FRUIT_PTS(FP))
    dut_a (.Clk(Clk), .Reset_n(Reset_n), .bus(ia.slave));
  pellet_tracker #(.REV_FRAMES(REV), .DOT_PTS(DP), .FRUIT_PTS(FP), .DOT_MASK(ONE_DOT))
    dut_b (.Clk(Clk), .Reset_n(Reset_n), .bus(ib.slave));

  int errors = 0;
  int checks = 0;

  bit md [42][42];
  int m_score, m_left, m_rev;
  bit m_en [3];
  bit m_clear;
  int fx [3];
  int fy [3];

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 42; c++)
      for (int r = 0; r < 42; r++) md[c][r] = DOT_INIT[c][r];
    m_score = 0; m_left = int'(DOT_INIT_COUNT); m_rev = 0; m_clear = 0;
    for (int k = 0; k < 3; k++) m_en[k] = 1;
  endtask

  task automatic model_frame(input int px, input int py, input bit frz);
    bit valid, dot;
    int nf;
    if (frz || m_clear) return;
    valid = px >= 56 && px <= 384 && py >= 56 && py <= 384
            && ((px - 56) % 8) == 0 && ((py - 56) % 8) == 0;
    dot = valid ? md[(px - 56) / 8][(py - 56) / 8] : 1'b0;
    nf = 0;
    for (int k = 0; k < 3; k++)
      if (m_en[k] && iabs(px - fx[k]) < 8 && iabs(py - fy[k]) < 8) begin
        m_en[k] = 0;
        nf++;
      end
    m_score = m_score + (dot ? DP : 0) + nf * FP;
    if (m_score > 65535) m_score = 65535;
    if (dot) begin
      md[(px - 56) / 8][(py - 56) / 8] = 0;
      if (m_left > 0) m_left--;
    end
    if (m_left == 0) begin m_clear = 1; m_rev = 0; end
    else if (nf > 0) m_rev = REV;
    else if (m_rev > 0) m_rev--;
  endtask

  task automatic check_all(input string ctx);
    dot_map_t exp_d;
    int bad_c, bad_r;
    chk({ctx, ".score"}, 32'(ia.score), 32'(m_score));
    chk({ctx, ".dots_left"}, 32'(ia.dots_left), 32'(m_left));
    chk({ctx, ".first_on"}, 32'(ia.first_on), 32'(m_en[0]));
    chk({ctx, ".second_on"}, 32'(ia.second_on), 32'(m_en[1]));
    chk({ctx, ".third_on"}, 32'(ia.third_on), 32'(m_en[2]));
    chk({ctx, ".reversal"}, 32'(ia.reversal), 32'(m_rev > 0));
    chk({ctx, ".level_clear"}, 32'(ia.level_clear), 32'(m_clear));
    bad_c = -1; bad_r = -1;
    for (int c = 0; c < 42; c++)
      for (int r = 0; r < 42; r++) begin
        exp_d[c][r] = md[c][r];
        if (ia.dots[c][r] !== md[c][r] && bad_c < 0) begin bad_c = c; bad_r = r; end
      end
    checks++;
    assert (ia.dots === exp_d) else begin
      errors++;
      $error("FAIL %s.dots first differing tile col=%0d row=%0d observed=%0b expected=%0b",
             ctx, bad_c, bad_r, ia.dots[bad_c][bad_r], md[bad_c][bad_r]);
    end
  endtask

  task automatic drive_fruits();
    for (int k = 0; k < 3; k++) begin
      ia.fruit_location[2*k]   = 10'(fx[k]);
      ia.fruit_location[2*k+1] = 10'(fy[k]);
    end
  endtask

  task automatic frame_a(input int px, input int py, input bit frz, input bit full);
    @(negedge Clk);
    ia.pacmanX = 10'(px); ia.pacmanY = 10'(py); ia.freeze = frz;
    drive_fruits();
    ia.frame_tick = 1'b1;
    @(negedge Clk);
    ia.frame_tick = 1'b0;
    model_frame(px, py, frz);
    @(negedge Clk);
    if (full) check_all("frame");
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic frame_b(input int px, input int py);
    @(negedge Clk);
    ib.pacmanX = 10'(px); ib.pacmanY = 10'(py); ib.frame_tick = 1'b1;
    @(negedge Clk);
    ib.frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int px, py, sel, k;
    ia.frame_tick = 0; ia.freeze = 0; ia.pacmanX = '0; ia.pacmanY = '0;
    ib.frame_tick = 0; ib.freeze = 0; ib.pacmanX = '0; ib.pacmanY = '0;
    fx[0] = 104; fy[0] = 96; fx[1] = 200; fy[1] = 300; fx[2] = 300; fy[2] = 200;
    drive_fruits();
    for (int i = 0; i < 6; i++) ib.fruit_location[i] = ia.fruit_location[i];
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk);

    chk("reset.score", 32'(ia.score), 32'd0);
    chk("reset.dots_left", 32'(ia.dots_left), 32'(DOT_INIT_COUNT));
    chk("reset.dot00", 32'(ia.dots[0][0]), 32'd1);
    check_all("reset");

    // Single-dot maze: eating the only dot clears the level and freezes scoring.
    chk("b.reset.dots_left", 32'(ib.dots_left), 32'd1);
    chk("b.reset.level_clear", 32'(ib.level_clear), 32'd0);
    frame_b(56, 56);
    chk("b.clear.level_clear", 32'(ib.level_clear), 32'd1);
    chk("b.clear.score", 32'(ib.score), 32'd10);
    chk("b.clear.dots_left", 32'(ib.dots_left), 32'd0);
    frame_b(100, 100);
    chk("b.after.score", 32'(ib.score), 32'd10);
    chk("b.after.first_on", 32'(ib.first_on), 32'd1);
    chk("b.after.reversal", 32'(ib.reversal), 32'd0);

    frame_a(56, 56, 0, 1);
    chk("dot.score", 32'(ia.score), 32'd10);
    chk("dot.dots_left", 32'(ia.dots_left), 32'(DOT_INIT_COUNT) - 32'd1);
    chk("dot.dot00", 32'(ia.dots[0][0]), 32'd0);
    frame_a(56, 56, 0, 1);
    chk("dot2.score", 32'(ia.score), 32'd10);
    chk("dot2.dots_left", 32'(ia.dots_left), 32'(DOT_INIT_COUNT) - 32'd1);

    do_reset();
    frame_a(60, 56, 0, 1);
    chk("unaligned.score", 32'(ia.score), 32'd0);

    do_reset();
    frame_a(100, 100, 0, 1);
    chk("fruit.first_on", 32'(ia.first_on), 32'd0);
    chk("fruit.score", 32'(ia.score), 32'd50);
    chk("fruit.reversal", 32'(ia.reversal), 32'd1);
    for (int i = 0; i < 299; i++) frame_a(0, 0, 0, 0);
    chk("rev299.reversal", 32'(ia.reversal), 32'd1);
    frame_a(0, 0, 0, 1);
    chk("rev300.reversal", 32'(ia.reversal), 32'd0);

    do_reset();
    frame_a(100, 100, 0, 1);
    for (int i = 0; i < 150; i++) frame_a(0, 0, 0, (i % 10) == 0);
    frame_a(200, 300, 0, 1);
    chk("reload.score", 32'(ia.score), 32'd100);
    for (int i = 0; i < 20; i++) frame_a(300, 200, 1, 1);
    chk("freeze.third_on", 32'(ia.third_on), 32'd1);
    for (int i = 0; i < 299; i++) frame_a(0, 0, 0, (i % 10) == 0);
    chk("reload299.reversal", 32'(ia.reversal), 32'd1);
    frame_a(0, 0, 0, 1);
    chk("reload300.reversal", 32'(ia.reversal), 32'd0);

    for (int i = 0; i < 600; i++) begin
      if ((i % 100) == 0) begin
        for (int j = 0; j < 3; j++) begin
          fx[j] = $urandom_range(40, 400);
          fy[j] = $urandom_range(40, 400);
        end
        do_reset();
      end
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        px = 56 + 8 * $urandom_range(0, 41);
        py = 56 + 8 * $urandom_range(0, 41);
      end else if (sel == 1) begin
        k = $urandom_range(0, 2);
        px = fx[k] + $urandom_range(0, 18) - 9;
        py = fy[k] + $urandom_range(0, 18) - 9;
      end else begin
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
      end
      frame_a(px, py, $urandom_range(0, 9) == 0, 1);
    end

    // Asynchronous reset between edges while frightened.
    fx[0] = 104; fy[0] = 96;
    do_reset();
    frame_a(100, 100, 0, 1);
    chk("pre_async.reversal", 32'(ia.reversal), 32'd1);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async.reversal", 32'(ia.reversal), 32'd0);
    chk("async.first_on", 32'(ia.first_on), 32'd1);
    chk("async.second_on", 32'(ia.second_on), 32'd1);
    chk("async.third_on", 32'(ia.third_on), 32'd1);
    chk("async.score", 32'(ia.score), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    check_all("async");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
